// File: rtl/isr_sequencer.sv
// In-Service Register and two-pulse INTA sequencer for the PIC.
// Define ISR_ROTATE_EN to rotate priority on non-specific EOI.
module isr_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ack_valid,
  input  logic [2:0] ack_level,
  input  logic       ack_done,
  input  logic       auto_eoi,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  output logic [7:0] isr,
  output logic       isr_any,
  output logic [2:0] highest_isr,
  output logic       busy,
  output logic [2:0] ack_vector,
  output logic [2:0] priority_base,
  output logic       seq_error
);

  typedef enum logic {StIdle, StWaitDone} state_e;

  localparam logic [7:0] TimeoutLast = 8'(ACK_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] ack_vector_q, ack_vector_d;
  logic [2:0] priority_base_q, priority_base_d;
  logic [7:0] cnt_q, cnt_d;
  logic       seq_error_q, seq_error_d;

  logic [7:0] set_mask;
  logic [7:0] eoi_clr;
  logic [7:0] ack_clr;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    logic [2:0] idx;
    idx         = 3'd0;
    highest_isr = 3'b111;
    for (int i = 7; i >= 0; i--) begin
      idx = priority_base_q + 3'(i);
      if (isr_q[idx]) highest_isr = idx;
    end
  end

  assign isr_any = |isr_q;

  always_comb begin
    eoi_clr = 8'h00;
    if (eoi_valid) begin
      if (eoi_specific)  eoi_clr = 8'b1 << eoi_level;
      else if (isr_any)  eoi_clr = 8'b1 << highest_isr;
    end
  end

  always_comb begin
    state_d      = state_q;
    ack_vector_d = ack_vector_q;
    cnt_d        = cnt_q;
    seq_error_d  = 1'b0;
    set_mask     = 8'h00;
    ack_clr      = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (ack_valid) begin
          set_mask     = 8'b1 << ack_level;
          ack_vector_d = ack_level;
          cnt_d        = 8'd0;
          state_d      = StWaitDone;
        end
        if (ack_done) seq_error_d = 1'b1;
      end
      StWaitDone: begin
        if (ack_valid) seq_error_d = 1'b1;
        if (ack_done) begin
          state_d = StIdle;
          if (auto_eoi) ack_clr = 8'b1 << ack_vector_q;
        end else if (cnt_q == TimeoutLast) begin
          ack_clr     = 8'b1 << ack_vector_q;
          seq_error_d = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Set is applied after the clear so a same-cycle ack wins.
    isr_d = (isr_q & ~(eoi_clr | ack_clr)) | set_mask;
  end

`ifdef ISR_ROTATE_EN
  always_comb begin
    priority_base_d = priority_base_q;
    if (eoi_valid && !eoi_specific && isr_any) priority_base_d = highest_isr + 3'd1;
  end
`else
  assign priority_base_d = 3'b000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      isr_q           <= 8'h00;
      ack_vector_q    <= 3'd0;
      priority_base_q <= 3'd0;
      cnt_q           <= 8'd0;
      seq_error_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      isr_q           <= isr_d;
      ack_vector_q    <= ack_vector_d;
      priority_base_q <= priority_base_d;
      cnt_q           <= cnt_d;
      seq_error_q     <= seq_error_d;
    end
  end

  assign isr           = isr_q;
  assign busy          = (state_q == StWaitDone);
  assign ack_vector    = ack_vector_q;
  assign priority_base = priority_base_q;
  assign seq_error     = seq_error_q;

endmodule

// File: tb/tb_isr_sequencer.sv
// Directed self-checking bench for isr_sequencer (ACK_TIMEOUT = 16).
module tb_isr_sequencer;

  logic       clk;
  logic       rst_n;
  logic       ack_valid;
  logic [2:0] ack_level;
  logic       ack_done;
  logic       auto_eoi;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic [7:0] isr;
  logic       isr_any;
  logic [2:0] highest_isr;
  logic       busy;
  logic [2:0] ack_vector;
  logic [2:0] priority_base;
  logic       seq_error;

  int n_checks;
  int n_fails;

  isr_sequencer #(.ACK_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ack_valid    (ack_valid),
    .ack_level    (ack_level),
    .ack_done     (ack_done),
    .auto_eoi     (auto_eoi),
    .eoi_valid    (eoi_valid),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
    .isr          (isr),
    .isr_any      (isr_any),
    .highest_isr  (highest_isr),
    .busy         (busy),
    .ack_vector   (ack_vector),
    .priority_base(priority_base),
    .seq_error    (seq_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ack(input logic [2:0] lvl);
    ack_valid = 1'b1;
    ack_level = lvl;
    cycle();
    ack_valid = 1'b0;
  endtask

  task automatic done(input logic aeoi);
    ack_done = 1'b1;
    auto_eoi = aeoi;
    cycle();
    ack_done = 1'b0;
    auto_eoi = 1'b0;
  endtask

  task automatic eoi(input logic spec, input logic [2:0] lvl);
    eoi_valid    = 1'b1;
    eoi_specific = spec;
    eoi_level    = lvl;
    cycle();
    eoi_valid    = 1'b0;
    eoi_specific = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    rst_n        = 1'b0;
    ack_valid    = 1'b0;
    ack_level    = 3'd0;
    ack_done     = 1'b0;
    auto_eoi     = 1'b0;
    eoi_valid    = 1'b0;
    eoi_specific = 1'b0;
    eoi_level    = 3'd0;
    #12;
    check_eq("rst_isr", isr, 8'h00);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_any", isr_any, 0);
    check_eq("rst_highest", highest_isr, 3'd7);
    check_eq("rst_vec", ack_vector, 0);
    check_eq("rst_base", priority_base, 0);
    check_eq("rst_err", seq_error, 0);
    rst_n = 1'b1;
    cycle();

    // Basic handshake, no AEOI
    ack(3'd5);
    check_eq("t1_isr", isr, 8'h20);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_vec", ack_vector, 5);
    done(1'b0);
    check_eq("t1_done_busy", busy, 0);
    check_eq("t1_done_isr", isr, 8'h20);
    check_eq("t1_highest", highest_isr, 5);

    // Non-specific then specific EOI
    ack(3'd3);
    done(1'b0);
    check_eq("t2_isr", isr, 8'h28);
    check_eq("t2_highest", highest_isr, 3);
    eoi(1'b0, 3'd0);
    check_eq("t2_ns_isr", isr, 8'h20);
    eoi(1'b1, 3'd5);
    check_eq("t2_sp_isr", isr, 8'h00);
    check_eq("t2_sp_highest", highest_isr, 7);
    check_eq("t2_sp_any", isr_any, 0);
    eoi(1'b1, 3'd2);
    check_eq("t2_noop_isr", isr, 8'h00);
    check_eq("t2_noop_err", seq_error, 0);

    // Auto-EOI, ack_done three cycles after ack_valid
    ack(3'd2);
    check_eq("t3_isr0", isr, 8'h04);
    cycle();
    check_eq("t3_isr1", isr, 8'h04);
    cycle();
    check_eq("t3_isr2", isr, 8'h04);
    check_eq("t3_busy2", busy, 1);
    done(1'b1);
    check_eq("t3_isr_clr", isr, 8'h00);
    check_eq("t3_busy", busy, 0);

    // Timeout after 16 cycles in WAIT_DONE
    ack(3'd4);
    check_eq("t4_isr0", isr, 8'h10);
    for (int i = 1; i <= 15; i++) cycle();
    check_eq("t4_isr15", isr, 8'h10);
    check_eq("t4_busy15", busy, 1);
    check_eq("t4_err15", seq_error, 0);
    cycle();
    check_eq("t4_isr16", isr, 8'h00);
    check_eq("t4_busy16", busy, 0);
    check_eq("t4_err16", seq_error, 1);
    cycle();
    check_eq("t4_err_pulse", seq_error, 0);

    // ack_done in IDLE is an error, isr untouched
    ack(3'd6);
    done(1'b0);
    done(1'b0);
    check_eq("t4b_err", seq_error, 1);
    check_eq("t4b_isr", isr, 8'h40);
    check_eq("t4b_busy", busy, 0);
    cycle();
    check_eq("t4b_err_pulse", seq_error, 0);
    eoi(1'b1, 3'd6);
    check_eq("t4b_clr", isr, 8'h00);

    // Same-cycle ack set and EOI clear on one bit: set wins
    ack(3'd1);
    done(1'b0);
    check_eq("t5_pre", isr, 8'h02);
    ack_valid    = 1'b1;
    ack_level    = 3'd1;
    eoi_valid    = 1'b1;
    eoi_specific = 1'b1;
    eoi_level    = 3'd1;
    cycle();
    ack_valid    = 1'b0;
    eoi_valid    = 1'b0;
    eoi_specific = 1'b0;
    check_eq("t5_isr", isr, 8'h02);
    check_eq("t5_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_isr", isr, 8'h00);
    check_eq("t5_rst_busy", busy, 0);
    #2;
    rst_n = 1'b1;
    cycle();

    // Rotation on non-specific EOI (or fixed base without the macro)
    ack(3'd0);
    done(1'b0);
    ack(3'd3);
    done(1'b0);
    check_eq("t6_isr", isr, 8'h09);
    eoi(1'b0, 3'd0);
    check_eq("t6_ns_isr", isr, 8'h08);
    check_eq("t6_highest", highest_isr, 3);
`ifdef ISR_ROTATE_EN
    check_eq("t6_base", priority_base, 1);
`else
    check_eq("t6_base", priority_base, 0);
`endif

    // EOI of the in-flight level keeps WAIT_DONE; extra ack_valid is an error
    ack(3'd7);
    check_eq("t7_isr", isr, 8'h88);
    eoi(1'b1, 3'd7);
    check_eq("t7_eoi_isr", isr, 8'h08);
    check_eq("t7_eoi_busy", busy, 1);
    ack(3'd2);
    check_eq("t7_err", seq_error, 1);
    check_eq("t7_isr_kept", isr, 8'h08);
    check_eq("t7_vec", ack_vector, 7);
    done(1'b0);
    check_eq("t7_busy", busy, 0);
    check_eq("t7_err_pulse", seq_error, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
